// File: rtl/elastic_exe_stage.sv
// elastic_exe_stage: N-deep elastic buffer between two pipeline stages.
// Carries DATA_W-bit packets over a send/ack handshake, duplicates copy packets
// (two output beats) and deletes terminated packets inside the stage.
// Optional feature macro: XSTG_BYPASS_EN enables a zero-latency pass-through
// when the buffer is empty and the downstream stage accepts in the same cycle.
module elastic_exe_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lopen,
    input  logic              send_i,
    output logic              ack_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              cp_i,
    input  logic              term_i,
    output logic              send_o,
    input  logic              ack_i,
    output logic [DATA_W-1:0] data_o,
    output logic              cppkt_o,
    output logic              term_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

    // Entry layout: {payload, copy flag}
    logic [DATA_W:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_phase;   // 1 = first beat of a copy packet already delivered
    logic               r_term;

    logic               w_full;
    logic               w_empty;
    logic               w_ack;
    logic [DATA_W:0]    w_head;
    logic               w_head_cp;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_bypass;
    logic               w_xfer;
    logic               w_pop;
    logic               w_push;

    assign w_full      = (r_count == FullCnt);
    assign w_empty     = (r_count == '0);
    // rst gates ack so it reads 0 while reset is held; full refuses even on a pop
    assign w_ack       = rst & lopen & ~w_full;
    assign w_head      = r_mem[r_rptr];
    assign w_head_cp   = w_head[0];
    assign w_head_data = w_head[DATA_W:1];

`ifdef XSTG_BYPASS_EN
    assign w_bypass = w_empty & send_i & w_ack & ~term_i & ~cp_i & ack_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_xfer = ~w_empty & ack_i;
    // A copy head stays put on its first transfer and pops on the second
    assign w_pop  = w_xfer & (~w_head_cp | r_phase);
    assign w_push = send_i & w_ack & ~term_i & ~w_bypass;

    // Output decode: head entry when buffered, bypassed input otherwise, else zero
    always_comb begin
        ack_o   = w_ack;
        send_o  = ~w_empty | w_bypass;
        cppkt_o = ~w_empty & r_phase;
        term_o  = r_term;
        count_o = r_count;
        data_o  = '0;
        if (!w_empty) begin
            data_o = w_head_data;
        end else if (w_bypass) begin
            data_o = data_i;
        end
    end

    // Payload storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {data_i, cp_i};
        end
    end

    // Pointers, occupancy, copy phase and terminate pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_phase <= 1'b0;
            r_term  <= 1'b0;
        end else begin
            r_term <= send_i & w_ack & term_i;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_xfer && w_head_cp) begin
                r_phase <= ~r_phase;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_exe_stage.sv
// Self-checking bench for elastic_exe_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based packet model.
module tb_elastic_exe_stage;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              lopen;
    logic              send_i;
    logic              ack_o;
    logic [DATA_W-1:0] data_i;
    logic              cp_i;
    logic              term_i;
    logic              send_o;
    logic              ack_i;
    logic [DATA_W-1:0] data_o;
    logic              cppkt_o;
    logic              term_o;
    logic [CNT_W-1:0]  count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              cp;
    } ent_t;

    ent_t q[$];
    logic m_phase = 1'b0;
    logic m_term  = 1'b0;

    always #5 clk = ~clk;

    elastic_exe_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lopen   (lopen),
        .send_i  (send_i),
        .ack_o   (ack_o),
        .data_i  (data_i),
        .cp_i    (cp_i),
        .term_i  (term_i),
        .send_o  (send_o),
        .ack_i   (ack_i),
        .data_o  (data_o),
        .cppkt_o (cppkt_o),
        .term_o  (term_o),
        .count_o (count_o)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model by what the coming rising edge should do.
    task automatic step(input logic r, input logic lo, input logic s,
                        input logic [DATA_W-1:0] d, input logic c, input logic t,
                        input logic a);
        logic e_ack, e_send, e_cppkt, byp, acc;
        logic [DATA_W-1:0] e_data;
        @(negedge clk);
        rst = r; lopen = lo; send_i = s; data_i = d; cp_i = c; term_i = t; ack_i = a;
        #1;
        if (!r) begin
            q.delete();
            m_phase = 1'b0;
            m_term  = 1'b0;
        end
        e_ack   = r && lo && (q.size() < DEPTH);
        e_send  = q.size() > 0;
        e_data  = (q.size() > 0) ? q[0].d : '0;
        e_cppkt = (q.size() > 0) && m_phase;
        byp     = 1'b0;
`ifdef XSTG_BYPASS_EN
        byp = (q.size() == 0) && s && e_ack && !t && !c && a;
        if (byp) begin
            e_send = 1'b1;
            e_data = d;
        end
`endif
        chk("ack_o",   DATA_W'(ack_o),   DATA_W'(e_ack));
        chk("send_o",  DATA_W'(send_o),  DATA_W'(e_send));
        chk("data_o",  data_o,           e_data);
        chk("cppkt_o", DATA_W'(cppkt_o), DATA_W'(e_cppkt));
        chk("term_o",  DATA_W'(term_o),  DATA_W'(m_term));
        chk("count_o", DATA_W'(count_o), DATA_W'(q.size()));
        if (r) begin
            acc    = s && e_ack;
            m_term = acc && t;
            if (q.size() > 0 && a) begin
                if (q[0].cp && !m_phase) begin
                    m_phase = 1'b1;
                end else begin
                    void'(q.pop_front());
                    m_phase = 1'b0;
                end
            end
            if (acc && !t && !byp) begin
                q.push_back('{d: d, cp: c});
            end
        end
    endtask

    initial begin
        rst = 1'b0; lopen = 1'b0; send_i = 1'b0; data_i = '0;
        cp_i = 1'b0; term_i = 1'b0; ack_i = 1'b0;

        // Reset and release
        step(0, 1, 1, 32'h11, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("rel_ack", DATA_W'(ack_o), 1);

        // Fill to DEPTH with downstream stalled; fifth send refused
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 32'hA0 + i, 0, 0, 0);
        end
        chk("t2_full_ack", DATA_W'(ack_o), 0);
        chk("t2_full_cnt", DATA_W'(count_o), 4);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 0, 1);
            chk("t2_order", data_o, 32'hA0 + i);
        end
        step(1, 1, 1, 32'hA4, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        chk("t2_last", data_o, 32'hA4);
        step(1, 1, 0, 0, 0, 0, 0);

        // Copy packet: two beats, then with a stalling downstream
        step(1, 1, 1, 32'h55, 1, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1);
        chk("t3_beat0", DATA_W'(cppkt_o), 0);
        step(1, 1, 0, 0, 0, 0, 1);
        chk("t3_beat1", DATA_W'(cppkt_o), 1);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h55, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, 0, 0, (i % 2) == 0);
        end

        // Terminate has priority over copy
        step(1, 1, 1, 32'h77, 1, 1, 1);
        step(1, 1, 0, 0, 0, 0, 1);
        chk("t4_term", DATA_W'(term_o), 1);
        step(1, 1, 0, 0, 0, 0, 1);

        // Full buffer with simultaneous pop and send: pop only
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 32'hB0 + i, 0, 0, 0);
        end
        step(1, 1, 1, 32'hBF, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("t5_cnt3", DATA_W'(count_o), 3);
        step(1, 1, 0, 0, 0, 0, 1);
        // Closed stage drains the remaining two without accepting
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 32'hC0 + i, 0, 0, 1);
        end

        // Empty buffer, accepting downstream: latency depends on bypass
        step(1, 1, 1, 32'h99, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1);

        // Reset in the middle of a copy
        step(1, 1, 1, 32'hD0, 1, 0, 0);
        step(1, 1, 1, 32'hD1, 0, 0, 1);
        step(0, 1, 1, 32'hD2, 0, 0, 1);
        chk("t1_rst_send", DATA_W'(send_o), 0);
        step(1, 1, 0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) < 7), $urandom(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
